fetch_unit: RTL and testbench

Instruction-fetch front end of the pipelined core: owns the fetch PC and issues instruction-memory reads over a req/ack handshake. It buffers returned words in a 2-entry prefetch FIFO and drives the Decode pipeline register. It consumes the controller's redirect and hazard outputs (`BranchTakenE`, `PCSrcW`, `PCWrPendingF`) plus the hazard unit's stall/flush lines, and squashes wrong-path fetches.

---
 rtl/fetch_unit.sv | 180 ++++++++++++++++++
 tb/tb_fetch_unit.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: fetch PC, imem req/ack handshake, 2-entry prefetch FIFO, Decode register.
// Optional discarded-response counter built only when FETCH_SQUASH_CNT_EN is defined.
`timescale 1ns/1ps
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        StallF,
   input  logic        StallD,
   input  logic        FlushD,
   input  logic        PCWrPendingF,
   input  logic        BranchTakenE,
   input  logic [31:0] BranchTargetE,
   input  logic        PCSrcW,
   input  logic [31:0] ResultW,
   output logic        IMemReq,
   output logic [31:0] IMemAddr,
   input  logic        IMemAck,
   input  logic [31:0] IMemRData,
   output logic [31:0] InstrD,
   output logic [31:0] PCD,
   output logic        ValidD,
   output logic [15:0] SquashCntF
);

   typedef enum logic [1:0] {S_FETCH, S_WAIT, S_DRAIN} state_t;
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fent_t;

   state_t      r_state, w_state_nxt;
   logic [31:0] r_pc, r_addr, r_pend;
   logic        r_req;
   logic [31:0] w_pc_nxt, w_addr_nxt, w_pend_nxt;
   logic        w_req_nxt;

   fent_t       r_fifo [2];
   logic [1:0]  r_cnt;
   logic [31:0] r_instr, r_pcd;
   logic        r_valid;

   logic        w_redirect, w_ack, w_push, w_pop, w_issue;
   logic [31:0] w_target;
   logic [2:0]  w_occ;

   assign w_redirect = BranchTakenE | PCSrcW;
   assign w_target   = BranchTakenE ? BranchTargetE : ResultW;
   assign w_ack      = IMemAck & r_req;
   assign w_push     = (r_state == S_WAIT) & w_ack & ~w_redirect;
   assign w_pop      = ~FlushD & ~StallD & (r_cnt != 2'd0);
   // occupancy after this edge; a new request only goes out if its slot is free
   assign w_occ      = {1'b0, r_cnt} + {2'b00, w_push} - {2'b00, w_pop};
   assign w_issue    = ~StallF & ~PCWrPendingF & (w_occ < 3'd2);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= S_FETCH;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_FETCH: if (!w_redirect && w_issue) w_state_nxt = S_WAIT;
         S_WAIT: begin
            if (w_redirect)           w_state_nxt = w_ack ? S_FETCH : S_DRAIN;
            else if (w_ack && !w_issue) w_state_nxt = S_FETCH;
         end
         S_DRAIN: if (w_ack) w_state_nxt = S_FETCH;
         default: w_state_nxt = S_FETCH;
      endcase
   end

   always_comb begin
      w_pc_nxt   = r_pc;
      w_addr_nxt = r_addr;
      w_pend_nxt = r_pend;
      w_req_nxt  = r_req;
      case (r_state)
         S_FETCH: begin
            if (w_redirect) w_pc_nxt = w_target;
            else if (w_issue) begin
               w_req_nxt  = 1'b1;
               w_addr_nxt = r_pc;
            end
         end
         S_WAIT: begin
            if (w_redirect) begin
               if (w_ack) begin
                  w_pc_nxt  = w_target;
                  w_req_nxt = 1'b0;
               end else begin
                  w_pend_nxt = w_target;
               end
            end else if (w_ack) begin
               w_pc_nxt = r_pc + 32'd4;
               if (w_issue) w_addr_nxt = r_pc + 32'd4;
               else         w_req_nxt  = 1'b0;
            end
         end
         S_DRAIN: begin
            // the newest redirect wins, including one arriving with the ack
            if (w_redirect) w_pend_nxt = w_target;
            if (w_ack) begin
               w_pc_nxt  = w_redirect ? w_target : r_pend;
               w_req_nxt = 1'b0;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_pc   <= RESET_PC;
         r_addr <= RESET_PC;
         r_pend <= RESET_PC;
         r_req  <= 1'b0;
      end else begin
         r_pc   <= w_pc_nxt;
         r_addr <= w_addr_nxt;
         r_pend <= w_pend_nxt;
         r_req  <= w_req_nxt;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)           r_cnt <= 2'd0;
      else if (w_redirect) r_cnt <= 2'd0;
      else                 r_cnt <= w_occ[1:0];
   end

   // head is slot 0; a pop shifts, and the push lands at the post-pop tail
   always_ff @(posedge clk) begin
      if (w_pop)  r_fifo[0] <= r_fifo[1];
      if (w_push) r_fifo[w_occ[1]] <= '{pc: r_addr, instr: IMemRData};
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_instr <= '0;
         r_pcd   <= '0;
         r_valid <= 1'b0;
      end else if (FlushD) begin
         r_instr <= '0;
         r_pcd   <= '0;
         r_valid <= 1'b0;
      end else if (!StallD) begin
         if (r_cnt != 2'd0) begin
            r_instr <= r_fifo[0].instr;
            r_pcd   <= r_fifo[0].pc;
            r_valid <= 1'b1;
         end else begin
            r_instr <= '0;
            r_valid <= 1'b0;
         end
      end
   end

`ifdef FETCH_SQUASH_CNT_EN
   logic        w_discard;
   logic [15:0] r_sq;
   assign w_discard = w_ack & (w_redirect | (r_state == S_DRAIN));
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                            r_sq <= '0;
      else if (w_discard && r_sq != 16'hFFFF) r_sq <= r_sq + 16'd1;
   end
   assign SquashCntF = r_sq;
`else
   assign SquashCntF = '0;
`endif

   assign IMemReq  = r_req;
   assign IMemAddr = r_addr;
   assign InstrD   = r_instr;
   assign PCD      = r_pcd;
   assign ValidD   = r_valid;

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: transaction-level reference model feeds a decode scoreboard,
// plus per-cycle checks of the request port, bubbles and squash count.
`timescale 1ns/1ps
module tb_fetch_unit;
   localparam logic [31:0] RPC = 32'h0000_0000;
   localparam logic [31:0] K   = 32'hA5A5_0000;

   logic        clk, reset;
   logic        StallF, StallD, FlushD, PCWrPendingF, BranchTakenE, PCSrcW, IMemAck;
   logic [31:0] BranchTargetE, ResultW, IMemRData;
   logic        IMemReq, ValidD;
   logic [31:0] IMemAddr, InstrD, PCD;
   logic [15:0] SquashCntF;

   fetch_unit #(.RESET_PC(RPC)) dut (
      .clk(clk), .reset(reset), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
      .PCWrPendingF(PCWrPendingF), .BranchTakenE(BranchTakenE), .BranchTargetE(BranchTargetE),
      .PCSrcW(PCSrcW), .ResultW(ResultW), .IMemReq(IMemReq), .IMemAddr(IMemAddr),
      .IMemAck(IMemAck), .IMemRData(IMemRData), .InstrD(InstrD), .PCD(PCD),
      .ValidD(ValidD), .SquashCntF(SquashCntF)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] ins;
   } item_t;

   item_t       m_fq[$];   // model prefetch buffer
   item_t       exp_q[$];  // expected Decode presentations, in order
   item_t       m_cur;
   bit          m_out, m_doomed, m_valid;
   logic [31:0] m_pc, m_addr, m_pend;
   int          m_sq;
   int          n_vec, n_err;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] exp_sq();
`ifdef FETCH_SQUASH_CNT_EN
      return 32'(m_sq);
`else
      return 32'd0;
`endif
   endfunction

   function automatic void model_reset();
      m_fq.delete();
      exp_q.delete();
      m_out = 0; m_doomed = 0; m_valid = 0;
      m_pc = RPC; m_addr = RPC; m_pend = RPC; m_sq = 0;
   endfunction

   // One clock of fetch behaviour, described as request/response transactions
   function automatic void model_step(input bit sf, sd, fd, pw, bt, input logic [31:0] bta,
                                      input bit ps, input logic [31:0] rw, input bit ack_in);
      bit redir, ack, kept, dropped, pop, issue;
      logic [31:0] tgt;
      int occ;
      redir   = bt | ps;
      tgt     = bt ? bta : rw;
      ack     = ack_in & m_out;
      kept    = ack && !m_doomed && !redir;
      dropped = ack && (m_doomed || redir);
      pop     = !fd && !sd && (m_fq.size() > 0);
      occ     = m_fq.size() + int'(kept) - int'(pop);
      issue   = !sf && !pw && (occ < 2);

      if (fd) m_valid = 0;
      else if (!sd) begin
         if (m_fq.size() > 0) begin
            m_cur = m_fq.pop_front();
            m_valid = 1;
         end else m_valid = 0;
      end
      if (m_valid) exp_q.push_back(m_cur);

      if (kept) m_fq.push_back('{m_addr, m_addr ^ K});
      if (redir) m_fq.delete();

      if (!m_out) begin
         if (redir) m_pc = tgt;
         else if (issue) begin m_out = 1; m_addr = m_pc; end
      end else if (!m_doomed) begin
         if (redir) begin
            if (ack) begin m_pc = tgt; m_out = 0; end
            else begin m_doomed = 1; m_pend = tgt; end
         end else if (ack) begin
            m_pc = m_pc + 4;
            if (issue) m_addr = m_pc; else m_out = 0;
         end
      end else begin
         if (redir) m_pend = tgt;
         if (ack) begin
            m_pc = m_pend; m_out = 0; m_doomed = 0;
         end
      end
      if (dropped && m_sq < 65535) m_sq++;
   endfunction

   task automatic check_cycle();
      chk("IMemReq", {31'b0, IMemReq}, {31'b0, m_out});
      if (m_out) chk("IMemAddr", IMemAddr, m_addr);
      chk("ValidD", {31'b0, ValidD}, {31'b0, m_valid});
      if (!m_valid) chk("InstrD_bubble", InstrD, 32'h0);
      chk("SquashCntF", {16'b0, SquashCntF}, exp_sq());
   endtask

   task automatic tick(input bit sf, sd, fd, pw, bt, input logic [31:0] bta,
                       input bit ps, input logic [31:0] rw, input bit want_ack);
      bit a;
      check_cycle();
      a = want_ack & IMemReq;
      StallF = sf; StallD = sd; FlushD = fd; PCWrPendingF = pw;
      BranchTakenE = bt; BranchTargetE = bta; PCSrcW = ps; ResultW = rw;
      IMemAck = a; IMemRData = IMemAddr ^ K;
      model_step(sf, sd, fd, pw, bt, bta, ps, rw, a);
      @(negedge clk);
   endtask

   task automatic ack_ticks(input int n);
      for (int i = 0; i < n; i++) tick(0, 0, 0, 0, 0, 32'h0, 0, 32'h0, 1);
   endtask

   task automatic rand_tick();
      bit sf, sd, fd, pw, bt, ps, wa;
      sf = ($urandom_range(0, 9) == 0);
      sd = ($urandom_range(0, 3) == 0);
      fd = ($urandom_range(0, 19) == 0);
      pw = ($urandom_range(0, 9) == 0);
      bt = ($urandom_range(0, 14) == 0);
      ps = ($urandom_range(0, 14) == 0);
      wa = ($urandom_range(0, 9) < 6);
      tick(sf, sd, fd, pw, bt, $urandom & 32'h0000_FFFC, ps, $urandom & 32'h0000_FFFC, wa);
   endtask

   // Monitor: every cycle Decode shows a real instruction, it must be the next expected one
   always @(negedge clk) begin : mon
      item_t e;
      if (ValidD === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL decode_unexpected: got pc %h instr %h, expected nothing", PCD, InstrD);
         end else begin
            e = exp_q.pop_front();
            chk("InstrD", InstrD, e.ins);
            chk("PCD", PCD, e.pc);
         end
      end
   end

   initial begin
      n_vec = 0; n_err = 0;
      StallF = 0; StallD = 0; FlushD = 0; PCWrPendingF = 0; BranchTakenE = 0; PCSrcW = 0;
      BranchTargetE = 0; ResultW = 0; IMemAck = 0; IMemRData = 0;
      reset = 1;
      repeat (3) @(negedge clk);
      reset = 0;
      model_reset();

      // zero-wait streaming from reset
      ack_ticks(3);
      chk("first_ValidD", {31'b0, ValidD}, 32'd1);
      chk("first_InstrD", InstrD, 32'hA5A5_0000);
      chk("first_PCD", PCD, 32'h0);
      ack_ticks(2);

      // Decode stall fills the buffer, release drains it in order
      repeat (3) tick(0, 1, 0, 0, 0, 32'h0, 0, 32'h0, 1);
      ack_ticks(4);

      // branch while a request is outstanding, ack arrives later
      tick(0, 0, 0, 0, 0, 32'h0, 0, 32'h0, 0);
      tick(0, 0, 0, 0, 1, 32'h100, 0, 32'h0, 0);
      tick(0, 0, 0, 0, 0, 32'h0, 0, 32'h0, 0);
      ack_ticks(5);

      // simultaneous branch and PC write: branch wins
      tick(0, 0, 0, 0, 1, 32'h200, 1, 32'h300, 1);
      ack_ticks(4);

      // PC write pending window, then resume at ResultW
      repeat (4) tick(0, 0, 0, 1, 0, 32'h0, 0, 32'h0, 1);
      tick(0, 0, 0, 0, 0, 32'h0, 1, 32'h40, 1);
      ack_ticks(4);

      // enter DRAIN, then reset mid-transaction with an ack in flight
      tick(0, 0, 0, 0, 0, 32'h0, 0, 32'h0, 0);
      tick(0, 0, 0, 0, 1, 32'h500, 0, 32'h0, 0);
      tick(0, 0, 0, 0, 0, 32'h0, 0, 32'h0, 0);
      check_cycle();
      #2 reset = 1;
      #1;
      chk("rst_IMemReq", {31'b0, IMemReq}, 32'd0);
      chk("rst_IMemAddr", IMemAddr, RPC);
      chk("rst_ValidD", {31'b0, ValidD}, 32'd0);
      chk("rst_InstrD", InstrD, 32'h0);
      chk("rst_PCD", PCD, 32'h0);
      chk("rst_SquashCntF", {16'b0, SquashCntF}, 32'd0);
      model_reset();
      IMemAck = 1; BranchTakenE = 0;
      @(negedge clk);
      reset = 0;
      ack_ticks(4);

      for (int i = 0; i < 3000; i++) rand_tick();
      ack_ticks(6);
      #1;
      chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
